// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encoding and op encoding for the memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner search for mem_arbiter: round-robin from last+1 with wrap,
// or lowest-index-first when ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] winner,
  output logic            any
);

`ifdef ARB_FIXED_PRIO_EN

  // The pointer is still maintained by the top but plays no part here.
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!any && req[IDXW'(k)]) begin
        winner = IDXW'(k);
        any    = 1'b1;
      end
    end
  end

`else

  logic [IDXW-1:0] cand;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(last) + k) % NREQ);
      if (!any && req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between NREQ requesters.
// Define ARB_FIXED_PRIO_EN to switch the winner search to fixed lowest-index priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          w_in,
  input  logic [NREQ*ADDR_W-1:0]   endr_in,
  input  logic [NREQ*DATA_W-1:0]   dado_in,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_endr,
  output logic [DATA_W-1:0]        mem_dado,
  output logic                     mem_w,
  input  logic [DATA_W-1:0]        mem_q
);

  localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

  state_t state, state_nxt;

  logic [IDXW-1:0]   sel, sel_nxt;
  logic [IDXW-1:0]   last, last_nxt;
  logic [IDXW-1:0]   winner;
  logic              any;
  logic              op, op_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NREQ-1:0]   gnt_nxt, done_nxt;
  logic [DATA_W-1:0] rdata_nxt, dado_nxt;
  logic [ADDR_W-1:0] endr_nxt;
  logic              w_nxt;

  logic [ADDR_W-1:0] endr_arr [NREQ];
  logic [DATA_W-1:0] dado_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign endr_arr[g] = endr_in[g*ADDR_W +: ADDR_W];
    assign dado_arr[g] = dado_in[g*DATA_W +: DATA_W];
  end

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    op_nxt    = op;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    done_nxt  = done;
    rdata_nxt = rdata;
    endr_nxt  = mem_endr;
    dado_nxt  = mem_dado;
    w_nxt     = mem_w;

    case (state)
      S_IDLE: begin
        done_nxt = '0;
        if (any) begin
          sel_nxt  = winner;
          gnt_nxt  = onehot(winner);
          endr_nxt = endr_arr[winner];
          op_nxt   = w_in[winner] ? OP_WRITE : OP_READ;
          if (w_in[winner]) begin
            dado_nxt = dado_arr[winner];
            w_nxt    = 1'b1;
          end else begin
            dado_nxt = '0;
            w_nxt    = 1'b0;
          end
          state_nxt = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (op == OP_WRITE) begin
          w_nxt     = 1'b0;
          done_nxt  = onehot(sel);
          state_nxt = S_DONE;
        end else begin
          cnt_nxt   = CNT_W'(MEM_LAT);
          state_nxt = S_WAIT;
        end
      end

      // mem_endr is left untouched here so the address stays stable for the read.
      S_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          rdata_nxt = mem_q;
          done_nxt  = onehot(sel);
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done_nxt  = '0;
        gnt_nxt   = '0;
        last_nxt  = sel;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel      <= '0;
      last     <= LAST_RST;
      op       <= OP_READ;
      cnt      <= '0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      mem_endr <= '0;
      mem_dado <= '0;
      mem_w    <= 1'b0;
    end else begin
      sel      <= sel_nxt;
      last     <= last_nxt;
      op       <= op_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      rdata    <= rdata_nxt;
      mem_endr <= endr_nxt;
      mem_dado <= dado_nxt;
      mem_w    <= w_nxt;
    end
  end

endmodule
